// File: rtl/oifs_rx_interface.sv
`default_nettype none
// ============================================================================
// Module      : oifs_rx_interface
// Description : FT2232H OIFS receive side. Deserialises FSDO frames into
//               DATA_W-bit words plus a source-channel bit on valid/ready,
//               requesting FSCLK suspension (o_hold) under back-pressure.
// Option      : define OIFS_RX_OVERRUN_EN to build the sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module oifs_rx_interface #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_srst_n,
    input  logic              i_tick,
    input  logic              i_fsdo,
    output logic              o_hold,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_channel,
    input  logic              i_ready,
    output logic              o_overrun
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SRC   = 2'd2,
        STALL = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              src_bit;
    logic              free;
    logic              load;
    logic              load_channel;

    // A word being drained this cycle frees the holding register for a load.
    assign free = !o_valid || i_ready;

    generate
        if (DATA_W == 1) begin : g_shift_single
            assign shift_next = i_fsdo;
        end else begin : g_shift_multi
            assign shift_next = {i_fsdo, shift_reg[DATA_W-1:1]};
        end
    endgenerate

    always_comb begin
        next_state   = state;
        load         = 1'b0;
        load_channel = src_bit;
        case (state)
            IDLE: begin
                if (i_tick && !i_fsdo) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (i_tick && (bit_cnt == LAST_BIT)) begin
                    next_state = SRC;
                end
            end
            SRC: begin
                if (i_tick) begin
                    load_channel = i_fsdo;
                    if (free) begin
                        load       = 1'b1;
                        next_state = IDLE;
                    end else begin
                        next_state = STALL;
                    end
                end
            end
            STALL: begin
                // Ticks here are a protocol violation and are ignored.
                if (free) begin
                    load       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            src_bit   <= 1'b0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_channel <= 1'b0;
            o_hold    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= '0;
            end else if (state == SHIFT && i_tick && bit_cnt != LAST_BIT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == SHIFT && i_tick) begin
                shift_reg <= shift_next;
            end

            if (state == SRC && i_tick) begin
                src_bit <= i_fsdo;
            end

            if (load) begin
                o_data    <= shift_reg;
                o_channel <= load_channel;
                o_valid   <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            o_hold <= (next_state == STALL);
        end
    end

`ifdef OIFS_RX_OVERRUN_EN
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            o_overrun <= 1'b0;
        end else if (state == STALL && i_tick) begin
            o_overrun <= 1'b1;
        end
    end
`else
    assign o_overrun = 1'b0;
`endif

endmodule
`default_nettype wire
